// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare match, optional
// auto-reload, write-1-to-clear status and a level interrupt.
module mmio_timer #(
  parameter int PRE_W = 16,
  parameter int AW    = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SEL,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [29:0] ADDR,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  localparam logic [AW-1:0] OFF_CTRL = AW'(0);
  localparam logic [AW-1:0] OFF_PRE  = AW'(1);
  localparam logic [AW-1:0] OFF_CNT  = AW'(2);
  localparam logic [AW-1:0] OFF_CMP  = AW'(3);
  localparam logic [AW-1:0] OFF_STAT = AW'(4);

  logic [2:0]       ctrl;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [31:0]      count;
  logic [31:0]      compare;
  logic             match;

  logic [AW-1:0]    offs;
  logic             wr_en;
  logic             wr_ctrl, wr_pre, wr_cnt, wr_cmp, wr_stat;
  logic             en, auto_reload, irq_en;
  logic             tick, hit, match_clr;
  logic [31:0]      rdata_p0;
  logic             unused_addr;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // An all-zero byte enable is not a write, so it must not disturb pre_cnt either.
  assign offs        = ADDR[AW-1:0];
  assign unused_addr = ^ADDR[29:AW];
  assign wr_en       = SEL && WE && (BE != 4'b0000);
  assign wr_ctrl     = wr_en && (offs == OFF_CTRL);
  assign wr_pre      = wr_en && (offs == OFF_PRE);
  assign wr_cnt      = wr_en && (offs == OFF_CNT);
  assign wr_cmp      = wr_en && (offs == OFF_CMP);
  assign wr_stat     = wr_en && (offs == OFF_STAT);

  assign en          = ctrl[0];
  assign auto_reload = ctrl[1];
  assign irq_en      = ctrl[2];

  assign tick      = en && (pre_cnt == prescale);
  assign hit       = (count == compare);
  assign match_clr = wr_stat && BE[0] && WD[0];

  assign IRQ = match && irq_en;

  always_comb begin
    rdata_p0 = '0;
    case (offs)
      OFF_CTRL: rdata_p0 = {29'd0, ctrl};
      OFF_PRE:  rdata_p0 = 32'(prescale);
      OFF_CNT:  rdata_p0 = count;
      OFF_CMP:  rdata_p0 = compare;
      OFF_STAT: rdata_p0 = {31'd0, match};
      default:  rdata_p0 = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_ctrl) ctrl     <= 3'(byte_merge({29'd0, ctrl}, WD, BE));
      if (wr_pre)  prescale <= PRE_W'(byte_merge(32'(prescale), WD, BE));
      if (wr_cmp)  compare  <= byte_merge(compare, WD, BE);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt <= '0;
    end else if (wr_pre || tick) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // A CPU write to COUNT beats the tick; the match below still sees the old COUNT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (wr_cnt) begin
      count <= byte_merge(count, WD, BE);
    end else if (tick) begin
      count <= (hit && auto_reload) ? 32'd0 : count + 32'd1;
    end
  end

  // A new match on the same edge as a clear leaves MATCH set.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      match <= 1'b0;
    end else begin
      match <= (tick && hit) || (match && !match_clr);
    end
  end

  // Read data reflects pre-edge state; deselected cycles return zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RD <= '0;
    end else begin
      RD <= SEL ? rdata_p0 : 32'd0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: bus reads feed a scoreboard of expected values,
// with direct checks on IRQ and on RD around the asynchronous reset.
module tb_mmio_timer;

  logic        CLK;
  logic        RESET_N;
  logic        SEL;
  logic        WE;
  logic [3:0]  BE;
  logic [29:0] ADDR;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  localparam logic [29:0] A_CTRL = 30'd0;
  localparam logic [29:0] A_PRE  = 30'd1;
  localparam logic [29:0] A_CNT  = 30'd2;
  localparam logic [29:0] A_CMP  = 30'd3;
  localparam logic [29:0] A_STAT = 30'd4;

  mmio_timer #(.PRE_W(16), .AW(3)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .SEL     (SEL),
    .WE      (WE),
    .BE      (BE),
    .ADDR    (ADDR),
    .WD      (WD),
    .RD      (RD),
    .IRQ     (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
    SEL = 1'b1; WE = 1'b1; ADDR = a; WD = d; BE = b;
    @(posedge CLK);
    #1;
    SEL = 1'b0; WE = 1'b0; BE = 4'b0000;
  endtask

  task automatic rd(input logic [29:0] a, input logic [31:0] e, input string tag);
    exp_t x;
    SEL = 1'b1; WE = 1'b0; ADDR = a; BE = 4'b0000;
    sb.push_back('{val: e, tag: tag});
    @(posedge CLK);
    #1;
    SEL = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk(x.tag, RD, x.val);
    end
  endtask

  initial begin
    RESET_N = 1'b0; SEL = 1'b0; WE = 1'b0; BE = 4'b0000; ADDR = '0; WD = '0;
    cyc(3);
    chk("reset_rd", RD, 32'd0);
    chk("reset_irq", {31'd0, IRQ}, 32'd0);

    // Byte lanes, unimplemented bits, ignored high address bits.
    RESET_N = 1'b1;
    wr(30'h2000_0003, 32'hFFFF_FFFF, 4'b1111);
    wr(A_CMP, 32'h0000_00AA, 4'b0001);
    rd(A_CMP, 32'hFFFF_FFAA, "bytelane");
    wr(A_CMP, 32'h0000_0000, 4'b0000);
    rd(A_CMP, 32'hFFFF_FFAA, "be0_noop");
    wr(A_CMP, 32'h0055_0000, 4'b0100);
    rd(A_CMP, 32'hFF55_FFAA, "lane2");
    wr(A_CTRL, 32'hFFFF_FFF8, 4'b1111);
    rd(A_CTRL, 32'd0, "ctrl_unimpl");
    wr(30'd6, 32'hFFFF_FFFF, 4'b1111);
    rd(30'd6, 32'd0, "off6");
    wr(A_PRE, 32'hFFFF_FFFF, 4'b1111);
    rd(A_PRE, 32'h0000_FFFF, "pre_width");

    // Prescale 3, compare 2, IRQ enabled.
    wr(A_PRE, 32'd3, 4'b1111);
    wr(A_CMP, 32'd2, 4'b1111);
    wr(A_CTRL, 32'd5, 4'b1111);
    for (int k = 1; k <= 16; k++) begin
      rd(A_CNT, 32'((k - 1) / 4), "pre_cnt_seq");
      chk("pre_irq", {31'd0, IRQ}, (k >= 12) ? 32'd1 : 32'd0);
    end
    rd(A_STAT, 32'd1, "pre_match");
    wr(A_CTRL, 32'd0, 4'b1111);
    chk("irqen_clr_irq", {31'd0, IRQ}, 32'd0);
    rd(A_STAT, 32'd1, "en0_match_kept");
    rd(A_CNT, 32'd4, "en0_cnt");
    cyc(5);
    rd(A_CNT, 32'd4, "en0_hold");

    // Auto-reload with prescale 0.
    wr(A_STAT, 32'd1, 4'b0001);
    rd(A_STAT, 32'd0, "w1c");
    wr(A_CNT, 32'd0, 4'b1111);
    wr(A_PRE, 32'd0, 4'b1111);
    wr(A_CMP, 32'd5, 4'b1111);
    wr(A_CTRL, 32'd7, 4'b1111);
    for (int k = 1; k <= 8; k++) begin
      rd(A_CNT, 32'((k - 1) % 6), "auto_seq");
      chk("auto_irq", {31'd0, IRQ}, (k >= 6) ? 32'd1 : 32'd0);
    end
    wr(A_STAT, 32'd1, 4'b0001);
    chk("irq_drop", {31'd0, IRQ}, 32'd0);
    wr(A_CTRL, 32'd0, 4'b1111);

    // Wrap at 2^32 and CPU write colliding with a tick.
    wr(A_CNT, 32'hFFFF_FFFF, 4'b1111);
    wr(A_CMP, 32'd7, 4'b1111);
    wr(A_CTRL, 32'd1, 4'b1111);
    rd(A_CNT, 32'hFFFF_FFFF, "wrap_before");
    rd(A_CNT, 32'd0, "wrap");
    wr(A_CNT, 32'h0000_0100, 4'b1111);
    rd(A_CNT, 32'h0000_0100, "collide");
    rd(A_CNT, 32'h0000_0101, "collide_next");
    wr(A_CTRL, 32'd0, 4'b1111);
    rd(A_STAT, 32'd0, "no_match");

    // Partial PRESCALE write restarts the prescaler.
    wr(A_PRE, 32'd3, 4'b1111);
    wr(A_CNT, 32'd0, 4'b1111);
    wr(A_CTRL, 32'd1, 4'b1111);
    cyc(2);
    wr(A_PRE, 32'd0, 4'b0010);
    for (int k = 1; k <= 5; k++) begin
      rd(A_CNT, (k == 5) ? 32'd1 : 32'd0, "pre_restart");
    end
    wr(A_CTRL, 32'd0, 4'b1111);
    rd(A_PRE, 32'd3, "pre_partial_val");

    // Clear and new match on the same edge.
    wr(A_PRE, 32'd0, 4'b1111);
    wr(A_CNT, 32'd0, 4'b1111);
    wr(A_CMP, 32'd3, 4'b1111);
    wr(A_CTRL, 32'd5, 4'b1111);
    rd(A_CNT, 32'd0, "sim_cnt0");
    rd(A_CNT, 32'd1, "sim_cnt1");
    rd(A_CNT, 32'd2, "sim_cnt2");
    wr(A_STAT, 32'd1, 4'b0001);
    chk("clr_vs_match_irq", {31'd0, IRQ}, 32'd1);
    rd(A_STAT, 32'd1, "clr_vs_match");

    // Asynchronous reset while counting at 0x40.
    wr(A_PRE, 32'h0000_00FF, 4'b1111);
    wr(A_CNT, 32'h0000_0040, 4'b1111);
    rd(A_CNT, 32'h0000_0040, "cnt40");
    chk("pre_reset_irq", {31'd0, IRQ}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rd", RD, 32'd0);
    chk("async_irq", {31'd0, IRQ}, 32'd0);
    cyc(2);
    RESET_N = 1'b1;
    wr(A_CMP, 32'd9, 4'b1111);
    rd(A_CMP, 32'd9, "first_edge_wr");
    rd(A_CNT, 32'd0, "rst_cnt");
    rd(A_CTRL, 32'd0, "rst_ctrl");
    rd(A_PRE, 32'd0, "rst_pre");
    rd(A_STAT, 32'd0, "rst_stat");
    cyc(3);
    rd(A_CNT, 32'd0, "no_residual");
    wr(A_PRE, 32'd1, 4'b1111);
    wr(A_CTRL, 32'd1, 4'b1111);
    rd(A_CNT, 32'd0, "first_tick_a");
    rd(A_CNT, 32'd0, "first_tick_b");
    rd(A_CNT, 32'd1, "first_tick");
    ADDR = A_CNT;
    cyc(1);
    chk("sel0_rd", RD, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
